// File: rtl/bch_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bch_decoder
// Brief    : Serial-input BCH(63,51) t=2 decoder, syndrome + direct solve + Chien.
// Revision : 1.0
// ============================================================================
module bch_decoder #(
    parameter int CORRECT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        data_in,
    output logic        ready,
    output logic [50:0] data_out,
    output logic        data_valid,
    output logic [1:0]  err_count,
    output logic        uncorrectable
);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        SOLVE = 2'd1,
        CHIEN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [5:0] C_ALPHA_62 = 6'h21;

    // GF(64) arithmetic, primitive polynomial x^6+x+1
    function automatic logic [5:0] gf_mul_a(input logic [5:0] a);
        return {a[4:0], 1'b0} ^ (a[5] ? 6'h03 : 6'h00);
    endfunction

    function automatic logic [5:0] gf_mul_ainv(input logic [5:0] a);
        return {1'b0, a[5:1]} ^ (a[0] ? C_ALPHA_62 : 6'h00);
    endfunction

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p;
        logic [5:0] aa;
        p  = 6'h00;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_mul_a(aa);
        end
        return p;
    endfunction

    // a^-1 = a^62 = a^2 * a^4 * a^8 * a^16 * a^32
    function automatic logic [5:0] gf_inv(input logic [5:0] a);
        logic [5:0] sq;
        logic [5:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 4; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [62:0] r_cw;
    logic [5:0]  r_s1;
    logic [5:0]  r_s3;
    logic [5:0]  r_s1_cube;
    logic [5:0]  r_s1_inv;
    logic [5:0]  r_sigma2;
    logic [1:0]  r_expect;
    logic        r_bad;
    logic [5:0]  r_x;
    logic [50:0] r_marks;
    logic [1:0]  r_roots;

    logic [5:0]  w_sigma2;
    logic [5:0]  w_eval;
    logic        w_hit;
    logic [1:0]  w_roots_nxt;
    logic        w_ok;

    assign ready = (r_state == RECV);

    always_ff @(posedge clk) begin
        if (rst) r_state <= RECV;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RECV:  if (valid_in && r_cnt == 6'd62) w_state_nxt = SOLVE;
            SOLVE: if (r_cnt == 6'd1)              w_state_nxt = CHIEN;
            CHIEN: if (r_cnt == 6'd0)              w_state_nxt = OUT;
            OUT:                                   w_state_nxt = RECV;
            default:                               w_state_nxt = RECV;
        endcase
    end

    assign w_sigma2 = (r_s1 == 6'h00) ? 6'h00 : gf_mul(r_s3 ^ r_s1_cube, r_s1_inv);

    // Locators are the roots themselves: X^2 + sigma1*X + sigma2 with sigma1 = S1
    assign w_eval      = gf_mul(r_x, r_x) ^ gf_mul(r_s1, r_x) ^ r_sigma2;
    assign w_hit       = (w_eval == 6'h00) && (r_s1 != 6'h00);
    assign w_roots_nxt = (w_hit && r_roots != 2'd3) ? r_roots + 2'd1 : r_roots;
    assign w_ok        = (w_roots_nxt == r_expect) && !r_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 6'd0;
            r_cw          <= '0;
            r_s1          <= 6'h00;
            r_s3          <= 6'h00;
            r_s1_cube     <= 6'h00;
            r_s1_inv      <= 6'h00;
            r_sigma2      <= 6'h00;
            r_expect      <= 2'd0;
            r_bad         <= 1'b0;
            r_x           <= 6'h00;
            r_marks       <= '0;
            r_roots       <= 2'd0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            err_count     <= 2'd0;
            uncorrectable <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (r_state)
                RECV: begin
                    if (valid_in) begin
                        r_cw  <= {r_cw[61:0], data_in};
                        r_s1  <= gf_mul_a(r_s1) ^ {5'd0, data_in};
                        r_s3  <= gf_mul_a(gf_mul_a(gf_mul_a(r_s3))) ^ {5'd0, data_in};
                        r_cnt <= (r_cnt == 6'd62) ? 6'd0 : r_cnt + 6'd1;
                    end
                end
                SOLVE: begin
                    if (r_cnt == 6'd0) begin
                        r_s1_cube <= gf_mul(gf_mul(r_s1, r_s1), r_s1);
                        r_s1_inv  <= gf_inv(r_s1);
                        r_cnt     <= 6'd1;
                    end else begin
                        r_sigma2 <= w_sigma2;
                        r_bad    <= (r_s1 == 6'h00) && (r_s3 != 6'h00);
                        if (r_s1 == 6'h00)           r_expect <= 2'd0;
                        else if (w_sigma2 == 6'h00)  r_expect <= 2'd1;
                        else                         r_expect <= 2'd2;
                        r_cnt   <= 6'd62;
                        r_x     <= C_ALPHA_62;
                        r_marks <= '0;
                        r_roots <= 2'd0;
                    end
                end
                CHIEN: begin
                    r_x     <= gf_mul_ainv(r_x);
                    r_roots <= w_roots_nxt;
                    // Only message positions j=62..12 need a flip mark
                    if (r_cnt >= 6'd12) r_marks <= {r_marks[49:0], w_hit};
                    if (r_cnt == 6'd0) begin
                        data_valid    <= 1'b1;
                        err_count     <= w_ok ? w_roots_nxt : 2'd0;
                        uncorrectable <= !w_ok;
                        if (w_ok && CORRECT != 0) data_out <= r_cw[62:12] ^ r_marks;
                        else                      data_out <= r_cw[62:12];
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                OUT: begin
                    r_s1  <= 6'h00;
                    r_s3  <= 6'h00;
                    r_cnt <= 6'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
